// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and types for the modulo-N up/down counter.
// Default geometry is a decade counter on a 4-bit bus.
// The direction encoding gives readable names to the raw dir input.
package counter_pkg;

   localparam int DEFAULT_MODULUS = 10;
   localparam int DEFAULT_WIDTH   = 4;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage : counter_pkg

// File: rtl/mod_n_updown_counter_next.sv
// Purpose: combinational next-count and wrap-flag logic for the modulo-N counter.
// Latency: zero (pure combinational; the caller registers both outputs).
// Backpressure: none; en=0 simply selects a hold of the current count.
module mod_n_next
   import counter_pkg::*;
#(
   parameter int MODULUS = DEFAULT_MODULUS,
   parameter int WIDTH   = DEFAULT_WIDTH
)
(
   input  logic [WIDTH-1:0] q,
   input  logic             dir,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q_next,
   output logic             wrap_next
);

   // Terminal codes in the counter's own width so every compare/add stays WIDTH bits.
   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_VAL = '0;
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

   dir_e dir_mode;
   logic load_ok;
   logic at_max;
   logic at_zero;

   assign dir_mode = dir_e'(dir);

   // Compare in 32 bits so MODULUS == 2**WIDTH does not truncate to zero.
   assign load_ok = (32'(load_val) < 32'(MODULUS));
   assign at_max  = (q == MAX_VAL);
   assign at_zero = (q == ZERO_VAL);

   // Select the next count: load beats enable; an out-of-range load lands on 0.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (load) begin
         q_next    = load_ok ? load_val : ZERO_VAL;
         wrap_next = 1'b0;
      end else if (en) begin
         if (dir_mode == DIR_UP) begin
            q_next    = at_max ? ZERO_VAL : (q + ONE_VAL);
            wrap_next = at_max;
         end else begin
            q_next    = at_zero ? MAX_VAL : (q - ONE_VAL);
            wrap_next = at_zero;
         end
      end
   end

endmodule : mod_n_next

// File: rtl/mod_n_updown_counter.sv
// Purpose: modulo-N up/down counter with enable, parallel load and a registered wrap pulse.
// Latency: one cycle from the sampling edge to q/wrap; both outputs come straight from flops.
// Backpressure: none; en=0 holds the count and clears wrap, suitable for cascaded decade chains.
module mod_n_updown_counter
   import counter_pkg::*;
#(
   parameter int MODULUS = DEFAULT_MODULUS,
   parameter int WIDTH   = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             dir,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap
);

   // Reject geometries that cannot hold the count range.
   if (MODULUS < 2) begin : g_bad_modulus
      $error("mod_n_updown_counter: MODULUS must be at least 2");
   end
   if ((WIDTH < 32) && ((64'd1 << WIDTH) < 64'(MODULUS))) begin : g_bad_width
      $error("mod_n_updown_counter: WIDTH too narrow for MODULUS");
   end

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   mod_n_next #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
   ) u_next (
      .q         (q),
      .dir       (dir),
      .en        (en),
      .load      (load),
      .load_val  (load_val),
      .q_next    (q_next),
      .wrap_next (wrap_next)
   );

   // Count and wrap registers; reset overrides every other command.
   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

endmodule : mod_n_updown_counter

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for the decade up/down counter.
// Stimulus pushes the hand-computed post-edge q/wrap into a queue;
// an independent monitor pops one entry per edge and compares.
module tb_mod_n_updown_counter;

   logic       clk;
   logic       reset;
   logic       dir;
   logic       en;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       wrap;

   typedef struct {
      int         idx;
      logic [3:0] q;
      logic       wrap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec    = 0;

   mod_n_updown_counter #(
      .MODULUS (10),
      .WIDTH   (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .dir      (dir),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one command, record what the next edge must produce, then move past that edge.
   task automatic step(input logic r, input logic d, input logic e, input logic l,
                       input logic [3:0] lv, input logic [3:0] eq, input logic ew);
      exp_t x;
      reset    = r;
      dir      = d;
      en       = e;
      load     = l;
      load_val = lv;
      x.idx  = vec;
      x.q    = eq;
      x.wrap = ew;
      exp_q.push_back(x);
      vec++;
      @(posedge clk);
      #2;
   endtask

   // Monitor: sample 1 time unit after each rising edge and check against the scoreboard.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            checks++;
            if (q !== x.q) begin
               errors++;
               $display("FAIL q vec %0d: got %0d expected %0d", x.idx, q, x.q);
            end
            checks++;
            if (wrap !== x.wrap) begin
               errors++;
               $display("FAIL wrap vec %0d: got %0b expected %0b", x.idx, wrap, x.wrap);
            end
            checks++;
            if (!(q < 4'd10)) begin
               errors++;
               $display("FAIL range vec %0d: got q=%0d expected q<10", x.idx, q);
            end
         end
      end
   end

   initial begin
      int budget;
      reset = 1'b1; dir = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0;

      // Reset state.
      step(1, 1, 1, 0, 0, 4'd0, 0);

      // Up for 12 cycles: 1..9, 0 (wrap), 1, 2.
      step(0, 1, 1, 0, 0, 4'd1, 0);
      step(0, 1, 1, 0, 0, 4'd2, 0);
      step(0, 1, 1, 0, 0, 4'd3, 0);
      step(0, 1, 1, 0, 0, 4'd4, 0);
      step(0, 1, 1, 0, 0, 4'd5, 0);
      step(0, 1, 1, 0, 0, 4'd6, 0);
      step(0, 1, 1, 0, 0, 4'd7, 0);
      step(0, 1, 1, 0, 0, 4'd8, 0);
      step(0, 1, 1, 0, 0, 4'd9, 0);
      step(0, 1, 1, 0, 0, 4'd0, 1);
      step(0, 1, 1, 0, 0, 4'd1, 0);
      step(0, 1, 1, 0, 0, 4'd2, 0);

      // Reset, then down 3: 9 (wrap), 8, 7.
      step(1, 0, 1, 0, 0, 4'd0, 0);
      step(0, 0, 1, 0, 0, 4'd9, 1);
      step(0, 0, 1, 0, 0, 4'd8, 0);
      step(0, 0, 1, 0, 0, 4'd7, 0);

      // Reset, count to 5, reset mid-count with en/dir active, resume from 0.
      step(1, 1, 1, 0, 0, 4'd0, 0);
      step(0, 1, 1, 0, 0, 4'd1, 0);
      step(0, 1, 1, 0, 0, 4'd2, 0);
      step(0, 1, 1, 0, 0, 4'd3, 0);
      step(0, 1, 1, 0, 0, 4'd4, 0);
      step(0, 1, 1, 0, 0, 4'd5, 0);
      step(1, 1, 1, 0, 0, 4'd0, 0);
      step(0, 1, 1, 0, 0, 4'd1, 0);

      // Loads: in-range, out-of-range (12, 10, 15), load beats en, load at 9 then wrap up.
      step(0, 1, 1, 1, 4'd7,  4'd7, 0);
      step(0, 1, 1, 1, 4'd12, 4'd0, 0);
      step(0, 0, 1, 1, 4'd3,  4'd3, 0);
      step(0, 1, 0, 1, 4'd10, 4'd0, 0);
      step(0, 1, 1, 1, 4'd15, 4'd0, 0);
      step(0, 1, 1, 1, 4'd9,  4'd9, 0);
      step(0, 1, 1, 0, 4'd0,  4'd0, 1);
      step(0, 1, 0, 0, 4'd0,  4'd0, 0);

      // Load and reset together: reset wins.
      step(1, 1, 1, 1, 4'd5, 4'd0, 0);

      // Hold at 4 for 3 cycles with en=0.
      step(0, 1, 1, 1, 4'd4, 4'd4, 0);
      step(0, 1, 0, 0, 4'd0, 4'd4, 0);
      step(0, 0, 0, 0, 4'd0, 4'd4, 0);
      step(0, 1, 0, 0, 4'd0, 4'd4, 0);

      // Direction changes from 0: 1, 0, 9 (wrap), 0 (wrap), 1, 0, 9 (wrap).
      step(1, 1, 1, 0, 0, 4'd0, 0);
      step(0, 1, 1, 0, 0, 4'd1, 0);
      step(0, 0, 1, 0, 0, 4'd0, 0);
      step(0, 0, 1, 0, 0, 4'd9, 1);
      step(0, 1, 1, 0, 0, 4'd0, 1);
      step(0, 1, 1, 0, 0, 4'd1, 0);
      step(0, 0, 1, 0, 0, 4'd0, 0);
      step(0, 0, 1, 0, 0, 4'd9, 1);

      // Drain the scoreboard with a bounded wait.
      en = 1'b0; load = 1'b0; reset = 1'b0;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mod_n_updown_counter
